// File: rtl/data_sync_sink.sv
// Receiving end of the clock-domain data synchronizer: acknowledges held-valid words,
// queues them in a fall-through FIFO and offers them downstream as a valid/ready stream.
module data_sync_sink #(
    parameter int W          = 4,
    parameter int DEPTH_LOG2 = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          sync_data,
    input  logic                  sync_data_valid,
    output logic                  sync_data_retrieved,
    output logic [W-1:0]          m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      accepted_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Handshake: a word is taken on an IDLE edge with sync_data_valid high and room in
    // the FIFO; sync_data_retrieved then stays high until valid is sampled low.
    // Downstream: a word leaves on every edge with m_valid && m_ready.
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [W-1:0]          mem_q [DEPTH];

    logic push;
    logic pop;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = !empty_q && m_ready;

        case (state_q)
            IDLE: begin
                // Gated by the registered full flag, so a pop cannot make room on the same edge.
                if (sync_data_valid && !full_q) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!sync_data_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        if (push && !pop) begin
            level_d = level_q + (DEPTH_LOG2 + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (DEPTH_LOG2 + 1)'(1);
        end

        full_d  = (level_d == FULL_LEVEL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sync_data;
        end
    end

    assign sync_data_retrieved = (state_q == ACK);
    assign m_data              = mem_q[rd_ptr_q];
    assign m_valid             = !empty_q;
    assign level               = level_q;
    assign full                = full_q;
    assign empty               = empty_q;
    assign accepted_count      = count_q;

    if (DEPTH < 2) begin : g_depth_check
        $error("data_sync_sink: DEPTH_LOG2 must be at least 1");
    end

endmodule

// File: tb/tb_data_sync_sink.sv
// Bench for data_sync_sink: directed handshake scenarios plus a randomized stream,
// checked every cycle against a queue-based model of the sink.
module tb_data_sync_sink;

    localparam int W          = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [W-1:0]        sync_data;
    logic                sync_data_valid;
    logic                sync_data_retrieved;
    logic [W-1:0]        m_data;
    logic                m_valid;
    logic                m_ready;
    logic [DEPTH_LOG2:0] level;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    accepted_count;

    logic                w_retrieved;
    logic [W-1:0]        w_m_data;
    logic                w_m_valid;
    logic [DEPTH_LOG2:0] w_level;
    logic                w_full;
    logic                w_empty;
    logic [2:0]          w_count;

    int n_vec  = 0;
    int n_fail = 0;
    int n_sent = 0;
    logic stream_done = 1'b0;

    // reference model state
    logic [W-1:0] exp_q[$];
    bit           m_ack = 1'b0;
    int           m_cnt = 0;

    always #5 clk = ~clk;

    data_sync_sink #(.W(W), .DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .sync_data           (sync_data),
        .sync_data_valid     (sync_data_valid),
        .sync_data_retrieved (sync_data_retrieved),
        .m_data              (m_data),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .level               (level),
        .full                (full),
        .empty               (empty),
        .accepted_count      (accepted_count)
    );

    data_sync_sink #(.W(W), .DEPTH_LOG2(DEPTH_LOG2), .CNT_W(3)) u_wrap (
        .clk                 (clk),
        .reset               (reset),
        .sync_data           (sync_data),
        .sync_data_valid     (sync_data_valid),
        .sync_data_retrieved (w_retrieved),
        .m_data              (w_m_data),
        .m_valid             (w_m_valid),
        .m_ready             (m_ready),
        .level               (w_level),
        .full                (w_full),
        .empty               (w_empty),
        .accepted_count      (w_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a word is taken when valid is high, no acknowledge is pending and fewer
    // than DEPTH words are held (occupancy before this edge's pop).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_ack = 1'b0;
            m_cnt = 0;
        end else begin
            bit take;
            bit give;
            take = !m_ack && sync_data_valid && (exp_q.size() < DEPTH);
            give = (exp_q.size() > 0) && m_ready;
            if (give) void'(exp_q.pop_front());
            if (take) begin
                exp_q.push_back(sync_data);
                m_cnt++;
            end
            if (take) m_ack = 1'b1;
            else if (!sync_data_valid) m_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("retrieved", sync_data_retrieved, m_ack);
        chk("m_valid", m_valid, exp_q.size() > 0);
        chk("level", level, exp_q.size());
        chk("full", full, exp_q.size() == DEPTH);
        chk("empty", empty, exp_q.size() == 0);
        chk("count", accepted_count, m_cnt % 65536);
        chk("wrap_count", w_count, m_cnt % 8);
        if (exp_q.size() > 0) chk("m_data", m_data, exp_q[0]);
    end

    // Call at a falling edge; waits a bounded number of cycles for the acknowledge level.
    task automatic wait_ret(input logic lvl, input string tag);
        int b = 0;
        while (sync_data_retrieved !== lvl && b < 60) begin
            @(negedge clk);
            b++;
        end
        chk(tag, sync_data_retrieved, lvl);
    endtask

    task automatic send_word(input logic [W-1:0] data, input int hold);
        @(negedge clk);
        sync_data       = data;
        sync_data_valid = 1'b1;
        @(negedge clk);
        wait_ret(1'b1, "ack_rise");
        repeat (hold) @(negedge clk);
        sync_data_valid = 1'b0;
        sync_data       = W'($urandom);
        @(negedge clk);
        wait_ret(1'b0, "ack_fall");
        n_sent++;
    endtask

    initial begin
        reset           = 1'b1;
        sync_data       = '0;
        sync_data_valid = 1'b0;
        m_ready         = 1'b0;
        #1;
        chk("rst_retrieved", sync_data_retrieved, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // single word, valid held 3 cycles after acknowledge
        send_word(4'hA, 3);
        chk("single_level", level, 1);
        chk("single_data", m_data, 4'hA);
        chk("single_count", accepted_count, 1);

        // drain, then fill to full with downstream stalled
        @(negedge clk); m_ready = 1'b1;
        @(negedge clk); m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(W'(i), 0);
        chk("fill_full", full, 1'b1);
        chk("fill_level", level, 4);

        // fifth word is held off until a single pop frees a slot
        @(negedge clk);
        sync_data       = 4'h5;
        sync_data_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("bp_no_ack", sync_data_retrieved, 1'b0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("bp_after_pop_level", level, 3);
        chk("bp_head", m_data, 4'h2);
        @(negedge clk);
        wait_ret(1'b1, "bp_ack_rise");
        chk("bp_level", level, 4);
        sync_data_valid = 1'b0;
        @(negedge clk);
        wait_ret(1'b0, "bp_ack_fall");
        n_sent++;
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        m_ready = 1'b0;

        // simultaneous push and pop at level 2
        send_word(4'h7, 0);
        send_word(4'h8, 0);
        @(negedge clk);
        sync_data       = 4'h9;
        sync_data_valid = 1'b1;
        m_ready         = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("pp_level", level, 2);
        chk("pp_head", m_data, 4'h8);
        sync_data_valid = 1'b0;
        @(negedge clk);
        wait_ret(1'b0, "pp_ack_fall");
        n_sent++;
        chk("pp_count", accepted_count, n_sent);

        // randomized stream with a jittering consumer
        fork
            begin
                for (int i = 0; i < 20; i++) send_word(W'($urandom), $urandom_range(0, 2));
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(negedge clk);
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("stream_count", accepted_count, n_sent);
        chk("stream_drained", empty, 1'b1);

        // reset in the middle of an acknowledge, valid kept high across it
        m_ready = 1'b0;
        @(negedge clk);
        sync_data       = 4'hC;
        sync_data_valid = 1'b1;
        @(negedge clk);
        wait_ret(1'b1, "mr_ack_rise");
        #2 reset = 1'b1;
        #1;
        chk("mr_retrieved", sync_data_retrieved, 1'b0);
        chk("mr_level", level, 0);
        chk("mr_m_valid", m_valid, 1'b0);
        n_sent = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wait_ret(1'b1, "mr_recapture");
        sync_data_valid = 1'b0;
        @(negedge clk);
        wait_ret(1'b0, "mr_ack_fall");
        n_sent++;
        chk("mr_count", accepted_count, 1);
        chk("mr_head", m_data, 4'hC);

        // eight more words: the 3-bit counter wraps to 1
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(W'($urandom), 0);
        chk("wrap_3bit", w_count, 3'd1);
        chk("wrap_16bit", accepted_count, 9);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
